// File: rtl/fifo_rd_upsizer_if.sv
// Bundles the FIFO read port, flush request and packed output stream of the upsizer.
// "master" is the upsizer side; "slave" is the surrounding FIFO/downstream environment.
interface fifo_rd_upsizer_if #(
  parameter int DSIZE = 8,
  parameter int RATIO = 4
);
  logic                   rempty;
  logic [DSIZE-1:0]       rdata;
  logic                   rinc;
  logic                   flush;
  logic                   o_valid;
  logic                   o_ready;
  logic [RATIO*DSIZE-1:0] o_data;
  logic [RATIO-1:0]       o_keep;
  logic                   busy;

  modport master (
    input  rempty, rdata, flush, o_ready,
    output rinc, o_valid, o_data, o_keep, busy
  );

  modport slave (
    output rempty, rdata, flush, o_ready,
    input  rinc, o_valid, o_data, o_keep, busy
  );
endinterface

// File: rtl/fifo_rd_upsizer.sv
// Packs RATIO consecutive FIFO words into one wide word on a registered valid/ready stream.
// A flush forces out the partial word with a lane-keep mask.
module fifo_rd_upsizer #(
  parameter int DSIZE = 8,
  parameter int RATIO = 4
) (
  input  logic                 rclk,
  input  logic                 rrst_n,
  fifo_rd_upsizer_if.master    bus
);
  localparam int              CW       = $clog2(RATIO + 1);
  localparam int              WW       = RATIO * DSIZE;
  localparam logic [CW-1:0]   LAST     = CW'(RATIO - 1);
  localparam logic [RATIO-1:0] KEEP_ALL = '1;

  logic [CW-1:0]    idx_q, idx_d;
  logic [WW-1:0]    acc_q, acc_d;
  logic             flush_pend_q, flush_pend_d;
  logic             o_valid_q, o_valid_d;
  logic [WW-1:0]    o_data_q, o_data_d;
  logic [RATIO-1:0] o_keep_q, o_keep_d;

  logic             slot_free;
  logic             pop;
  logic             flush_eff;
  logic [CW-1:0]    cnt;
  logic [WW-1:0]    acc_new;
  logic [WW-1:0]    part_data;
  logic [RATIO-1:0] keep_part;

  assign slot_free = !o_valid_q || bus.o_ready;
  // The last lane may only be popped when the output register can take the full word.
  assign pop       = rrst_n && !bus.rempty && !flush_pend_q && ((idx_q != LAST) || slot_free);
  assign flush_eff = bus.flush || flush_pend_q;
  assign cnt       = idx_q + CW'(pop);

  generate
    for (genvar gi = 0; gi < RATIO; gi++) begin : g_lane
      assign acc_new[gi*DSIZE +: DSIZE] = (pop && (idx_q == CW'(gi))) ? bus.rdata
                                                                      : acc_q[gi*DSIZE +: DSIZE];
      assign keep_part[gi]               = (cnt > CW'(gi));
      assign part_data[gi*DSIZE +: DSIZE] = keep_part[gi] ? acc_new[gi*DSIZE +: DSIZE] : '0;
    end
  endgenerate

  always_comb begin
    idx_d        = idx_q;
    acc_d        = acc_new;
    flush_pend_d = flush_pend_q;
    o_valid_d    = o_valid_q;
    o_data_d     = o_data_q;
    o_keep_d     = o_keep_q;
    if (pop && (idx_q == LAST)) begin
      o_data_d     = acc_new;
      o_keep_d     = KEEP_ALL;
      o_valid_d    = 1'b1;
      idx_d        = '0;
      flush_pend_d = 1'b0;
      acc_d        = '0;
    end else if (flush_eff && (cnt != '0)) begin
      if (slot_free) begin
        o_data_d     = part_data;
        o_keep_d     = keep_part;
        o_valid_d    = 1'b1;
        idx_d        = '0;
        flush_pend_d = 1'b0;
        acc_d        = '0;
      end else begin
        flush_pend_d = 1'b1;
        idx_d        = cnt;
      end
    end else begin
      // An empty flush is simply dropped.
      if (flush_eff) begin
        flush_pend_d = 1'b0;
      end
      idx_d = cnt;
      if (o_valid_q && bus.o_ready) begin
        o_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      idx_q        <= '0;
      acc_q        <= '0;
      flush_pend_q <= 1'b0;
      o_valid_q    <= 1'b0;
      o_data_q     <= '0;
      o_keep_q     <= '0;
    end else begin
      idx_q        <= idx_d;
      acc_q        <= acc_d;
      flush_pend_q <= flush_pend_d;
      o_valid_q    <= o_valid_d;
      o_data_q     <= o_data_d;
      o_keep_q     <= o_keep_d;
    end
  end

  assign bus.rinc    = pop;
  assign bus.o_valid = o_valid_q;
  assign bus.o_data  = o_data_q;
  assign bus.o_keep  = o_keep_q;
  assign bus.busy    = (idx_q != '0) || o_valid_q || flush_pend_q;
endmodule

// File: tb/tb_fifo_rd_upsizer.sv
// Directed bench for fifo_rd_upsizer (DSIZE=8, RATIO=4) with a simple FIFO model on the read port.
module tb_fifo_rd_upsizer;
  localparam int DSIZE = 8;
  localparam int RATIO = 4;

  logic rclk = 1'b0;
  logic rrst_n = 1'b0;
  always #5 rclk = ~rclk;

  fifo_rd_upsizer_if #(.DSIZE(DSIZE), .RATIO(RATIO)) u_if ();

  fifo_rd_upsizer #(.DSIZE(DSIZE), .RATIO(RATIO)) u_dut (
    .rclk   (rclk),
    .rrst_n (rrst_n),
    .bus    (u_if.master)
  );

  logic [7:0]  fifo_mem [64];
  int          wr_ptr = 0;
  int          rd_ptr = 0;
  int          pop_cnt = 0;
  logic [31:0] rec_data [32];
  logic [3:0]  rec_keep [32];
  int          rec_cnt = 0;
  int          n_checks = 0;
  int          n_errors = 0;
  int          base;

  assign u_if.rempty = (wr_ptr == rd_ptr);
  assign u_if.rdata  = fifo_mem[rd_ptr[5:0]];

  // FIFO head advance and output handshake capture.
  always @(posedge rclk) begin
    if (u_if.rinc) begin
      rd_ptr  <= rd_ptr + 1;
      pop_cnt <= pop_cnt + 1;
    end
    if (rrst_n && u_if.o_valid && u_if.o_ready) begin
      rec_data[rec_cnt[4:0]] <= u_if.o_data;
      rec_keep[rec_cnt[4:0]] <= u_if.o_keep;
      rec_cnt                <= rec_cnt + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end else begin
      $display("ok   %s: %h", tag, got);
    end
  endtask

  task automatic push(input logic [7:0] v);
    fifo_mem[wr_ptr[5:0]] = v;
    wr_ptr = wr_ptr + 1;
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge rclk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    u_if.o_ready = 1'b0;
    u_if.flush   = 1'b0;
    tick(2);
    check("rst_valid", 32'(u_if.o_valid), 32'h0);
    check("rst_data",  u_if.o_data, 32'h0);
    check("rst_keep",  32'(u_if.o_keep), 32'h0);
    check("rst_busy",  32'(u_if.busy), 32'h0);
    push(8'h11); push(8'h22); push(8'h33); push(8'h44);
    #1;
    check("rst_rinc_blocked", 32'(u_if.rinc), 32'h0);

    // Full word with o_ready held high
    rrst_n       = 1'b1;
    u_if.o_ready = 1'b1;
    #1;
    check("t1_rinc0", 32'(u_if.rinc), 32'h1);
    for (int i = 1; i < 4; i++) begin
      tick(1);
      check($sformatf("t1_rinc%0d", i), 32'(u_if.rinc), 32'h1);
    end
    tick(1);
    check("t1_valid", 32'(u_if.o_valid), 32'h1);
    check("t1_data",  u_if.o_data, 32'h44332211);
    check("t1_keep",  32'(u_if.o_keep), 32'hF);
    check("t1_rinc_empty", 32'(u_if.rinc), 32'h0);
    tick(1);
    check("t1_valid_drop", 32'(u_if.o_valid), 32'h0);
    check("t1_rec_cnt", 32'(rec_cnt), 32'd1);
    check("t1_rec0", rec_data[0], 32'h44332211);

    // Back-pressure: 12 words with o_ready low
    u_if.o_ready = 1'b0;
    base = pop_cnt;
    for (int i = 1; i <= 12; i++) push(8'(i));
    tick(14);
    check("t2_hold_data", u_if.o_data, 32'h04030201);
    check("t2_hold_valid", 32'(u_if.o_valid), 32'h1);
    check("t2_pops", 32'(pop_cnt - base), 32'd7);
    check("t2_idx", 32'(u_dut.idx_q), 32'd3);
    check("t2_rinc_stall", 32'(u_if.rinc), 32'h0);
    u_if.o_ready = 1'b1;
    tick(12);
    check("t2_rec_cnt", 32'(rec_cnt), 32'd4);
    check("t2_rec1", rec_data[1], 32'h04030201);
    check("t2_rec2", rec_data[2], 32'h08070605);
    check("t2_rec3", rec_data[3], 32'h0C0B0A09);
    check("t2_pops_all", 32'(pop_cnt - base), 32'd12);
    check("t2_valid_idle", 32'(u_if.o_valid), 32'h0);

    // Flush of a two-lane partial word
    push(8'hAA); push(8'hBB);
    tick(2);
    u_if.flush = 1'b1;
    tick(1);
    u_if.flush = 1'b0;
    check("t3_valid", 32'(u_if.o_valid), 32'h1);
    check("t3_data",  u_if.o_data, 32'h0000BBAA);
    check("t3_keep",  32'(u_if.o_keep), 32'h3);
    check("t3_idx",   32'(u_dut.idx_q), 32'd0);
    check("t3_busy",  32'(u_if.busy), 32'h1);
    tick(1);
    check("t3_busy_drop", 32'(u_if.busy), 32'h0);
    check("t3_rec_cnt", 32'(rec_cnt), 32'd5);

    // Flush held pending behind a stalled full word
    u_if.o_ready = 1'b0;
    push(8'h41); push(8'h42); push(8'h43); push(8'h44); push(8'h51);
    tick(7);
    check("t4_full_data", u_if.o_data, 32'h44434241);
    check("t4_idx1", 32'(u_dut.idx_q), 32'd1);
    u_if.flush = 1'b1;
    tick(1);
    u_if.flush = 1'b0;
    push(8'h61);
    #1;
    check("t4_pend", 32'(u_dut.flush_pend_q), 32'h1);
    check("t4_rinc_blocked", 32'(u_if.rinc), 32'h0);
    tick(2);
    check("t4_hold_data", u_if.o_data, 32'h44434241);
    check("t4_rinc_still", 32'(u_if.rinc), 32'h0);
    u_if.o_ready = 1'b1;
    tick(1);
    check("t4_part_valid", 32'(u_if.o_valid), 32'h1);
    check("t4_part_data",  u_if.o_data, 32'h00000051);
    check("t4_part_keep",  32'(u_if.o_keep), 32'h1);
    check("t4_pend_clr",   32'(u_dut.flush_pend_q), 32'h0);
    tick(1);
    check("t4_rec_cnt", 32'(rec_cnt), 32'd7);
    check("t4_rec5", rec_data[5], 32'h44434241);
    check("t4_rec5k", 32'(rec_keep[5]), 32'hF);
    check("t4_rec6", rec_data[6], 32'h00000051);
    check("t4_rec6k", 32'(rec_keep[6]), 32'h1);
    check("t4_resume_idx", 32'(u_dut.idx_q), 32'd1);
    u_if.flush = 1'b1;
    tick(1);
    u_if.flush = 1'b0;
    check("t4_tail_data", u_if.o_data, 32'h00000061);
    tick(1);

    // Empty flush is dropped
    base = rec_cnt;
    u_if.flush = 1'b1;
    tick(1);
    u_if.flush = 1'b0;
    check("t5_empty_valid", 32'(u_if.o_valid), 32'h0);
    check("t5_empty_pend",  32'(u_dut.flush_pend_q), 32'h0);
    tick(1);
    check("t5_empty_rec", 32'(rec_cnt - base), 32'd0);

    // Flush coinciding with the third pop
    push(8'h71); push(8'h72); push(8'h73);
    tick(2);
    u_if.flush = 1'b1;
    tick(1);
    u_if.flush = 1'b0;
    check("t5_part_valid", 32'(u_if.o_valid), 32'h1);
    check("t5_part_data",  u_if.o_data, 32'h00737271);
    check("t5_part_keep",  32'(u_if.o_keep), 32'h7);
    check("t5_part_idx",   32'(u_dut.idx_q), 32'd0);
    tick(1);

    // Asynchronous reset mid-word
    u_if.o_ready = 1'b0;
    push(8'h81); push(8'h82); push(8'h83); push(8'h84); push(8'h91); push(8'h92);
    tick(8);
    check("t6_pre_valid", 32'(u_if.o_valid), 32'h1);
    check("t6_pre_idx",   32'(u_dut.idx_q), 32'd2);
    #2;
    rrst_n = 1'b0;
    #1;
    check("t6_rst_valid", 32'(u_if.o_valid), 32'h0);
    check("t6_rst_data",  u_if.o_data, 32'h0);
    check("t6_rst_keep",  32'(u_if.o_keep), 32'h0);
    push(8'hA1); push(8'hA2); push(8'hA3); push(8'hA4);
    #1;
    check("t6_rst_rinc", 32'(u_if.rinc), 32'h0);
    tick(1);
    rrst_n       = 1'b1;
    u_if.o_ready = 1'b1;
    base = rec_cnt;
    tick(4);
    check("t6_new_valid", 32'(u_if.o_valid), 32'h1);
    check("t6_new_data",  u_if.o_data, 32'hA4A3A2A1);
    check("t6_new_keep",  32'(u_if.o_keep), 32'hF);
    tick(1);
    check("t6_new_rec", 32'(rec_cnt - base), 32'd1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
